// File: rtl/obi_arb_pkg.sv
// Shared types for the two-port OBI data-bus arbiter: FSM states, requester IDs,
// the request payload, and the tie-break helper.
package obi_arb_pkg;

    localparam int unsigned PORT_ID_W = 1;
    localparam int unsigned BE_W      = 4;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    typedef logic [PORT_ID_W-1:0] port_id_t;

    localparam port_id_t PORT0 = 1'b0;
    localparam port_id_t PORT1 = 1'b1;

    typedef struct packed {
        logic              we;
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } obi_req_t;

    // Lone requester wins; on a tie, prefer1 selects port 1.
    function automatic port_id_t pick_winner(input logic req0, input logic req1,
                                             input logic prefer1);
        if (req0 && req1) begin
            return prefer1 ? PORT1 : PORT0;
        end
        return (req1 && !req0) ? PORT1 : PORT0;
    endfunction

endpackage

// File: rtl/obi_arb_id_fifo.sv
// In-order FIFO of requester IDs for accepted-but-unanswered transfers.
// Push is refused when full unless a pop happens in the same cycle; pop is ignored when empty.
module obi_arb_id_fifo
    import obi_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  port_id_t                     i_id,
    output port_id_t                     o_head,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    port_id_t           r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_push;
    logic               w_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_pop  = i_pop & (r_count != '0);
    assign w_push = i_push & ((r_count != CNT_W'(DEPTH)) | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= PORT0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_id;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/obi_dbus_arbiter.sv
// Two-requester OBI data-port arbiter in front of the OBI-to-AHB adapter, with in-order response routing.
// Define OBI_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default is round-robin.
module obi_dbus_arbiter
    import obi_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                hclk_i,
    input  logic                hresetn_i,
    input  logic                s0_req_i,
    output logic                s0_gnt_o,
    input  logic                s0_we_i,
    input  logic [BE_W-1:0]     s0_be_i,
    input  logic [ADDR_W-1:0]   s0_addr_i,
    input  logic [DATA_W-1:0]   s0_wdata_i,
    output logic                s0_rvalid_o,
    output logic [DATA_W-1:0]   s0_rdata_o,
    output logic                s0_err_o,
    input  logic                s1_req_i,
    output logic                s1_gnt_o,
    input  logic                s1_we_i,
    input  logic [BE_W-1:0]     s1_be_i,
    input  logic [ADDR_W-1:0]   s1_addr_i,
    input  logic [DATA_W-1:0]   s1_wdata_i,
    output logic                s1_rvalid_o,
    output logic [DATA_W-1:0]   s1_rdata_o,
    output logic                s1_err_o,
    output logic                m_req_o,
    input  logic                m_gnt_i,
    output logic                m_we_o,
    output logic [BE_W-1:0]     m_be_o,
    output logic [ADDR_W-1:0]   m_addr_o,
    output logic [DATA_W-1:0]   m_wdata_o,
    input  logic                m_rvalid_i,
    input  logic [DATA_W-1:0]   m_rdata_i,
    input  logic                m_err_i,
    output logic                m_pending_o,
    output logic                proto_err_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    arb_state_e         r_state;
    arb_state_e         w_state_nxt;
    port_id_t           r_sel;
    port_id_t           w_sel;
    port_id_t           w_win;
    port_id_t           w_head;
    logic               w_req;
    logic               w_accept;
    logic               w_any_req;
    logic               w_room;
    logic               w_prefer1;
    logic               w_full;
    logic               w_empty;
    logic               w_rsp;
    logic [CNT_W-1:0]   w_count;
    logic               r_proto_err;
    obi_req_t           w_s0;
    obi_req_t           w_s1;
    obi_req_t           w_m;

    assign w_any_req = s0_req_i | s1_req_i;
    // A slot frees up in the same cycle a response retires, so allow a start then.
    assign w_room    = (w_count < CNT_W'(MAX_OUTSTANDING)) | m_rvalid_i;

`ifdef OBI_ARB_FIXED_PRIO_EN
    assign w_prefer1 = 1'b0;
`else
    port_id_t r_last_grant;

    always_ff @(posedge hclk_i or negedge hresetn_i) begin
        if (!hresetn_i) begin
            r_last_grant <= PORT1;
        end else if (w_accept) begin
            r_last_grant <= w_sel;
        end
    end

    assign w_prefer1 = (r_last_grant == PORT0);
`endif

    assign w_win = pick_winner(s0_req_i, s1_req_i, w_prefer1);

    // State register plus the held selection
    always_ff @(posedge hclk_i or negedge hresetn_i) begin
        if (!hresetn_i) begin
            r_state <= ARB_IDLE;
            r_sel   <= PORT0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel;
        end
    end

    // Next state and request: once presented, the request is held until granted
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_sel       = r_sel;
        case (r_state)
            ARB_IDLE: begin
                w_sel = w_win;
                if (w_any_req && w_room) begin
                    w_req = 1'b1;
                    if (!m_gnt_i) begin
                        w_state_nxt = ARB_HOLD;
                    end
                end
            end
            ARB_HOLD: begin
                w_req = 1'b1;
                if (m_gnt_i) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    assign w_accept = w_req & m_gnt_i;

    assign w_s0 = '{we: s0_we_i, be: s0_be_i, addr: s0_addr_i, wdata: s0_wdata_i};
    assign w_s1 = '{we: s1_we_i, be: s1_be_i, addr: s1_addr_i, wdata: s1_wdata_i};
    assign w_m  = !w_req ? '0 : ((w_sel == PORT1) ? w_s1 : w_s0);

    assign m_req_o   = w_req;
    assign m_we_o    = w_m.we;
    assign m_be_o    = w_m.be;
    assign m_addr_o  = w_m.addr;
    assign m_wdata_o = w_m.wdata;
    assign s0_gnt_o  = w_accept & (w_sel == PORT0);
    assign s1_gnt_o  = w_accept & (w_sel == PORT1);

    obi_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (hclk_i),
        .rst_n   (hresetn_i),
        .i_push  (w_accept),
        .i_pop   (m_rvalid_i),
        .i_id    (w_sel),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign m_pending_o = w_full & ~m_rvalid_i;

    // Responses go to the oldest outstanding requester; stray ones are dropped
    assign w_rsp       = m_rvalid_i & ~w_empty;
    assign s0_rvalid_o = w_rsp & (w_head == PORT0);
    assign s1_rvalid_o = w_rsp & (w_head == PORT1);
    assign s0_rdata_o  = s0_rvalid_o ? m_rdata_i : '0;
    assign s1_rdata_o  = s1_rvalid_o ? m_rdata_i : '0;
    assign s0_err_o    = s0_rvalid_o & m_err_i;
    assign s1_err_o    = s1_rvalid_o & m_err_i;

    always_ff @(posedge hclk_i or negedge hresetn_i) begin
        if (!hresetn_i) begin
            r_proto_err <= 1'b0;
        end else if (m_rvalid_i && w_empty) begin
            r_proto_err <= 1'b1;
        end
    end

    assign proto_err_o = r_proto_err;

endmodule

// File: tb/tb_obi_dbus_arbiter.sv
// Self-checking bench for obi_dbus_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_obi_dbus_arbiter;

    localparam int MAX = 2;
`ifdef OBI_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s0_req_i, s0_gnt_o, s0_we_i, s0_rvalid_o, s0_err_o;
    logic [3:0]  s0_be_i;
    logic [31:0] s0_addr_i, s0_wdata_i, s0_rdata_o;
    logic        s1_req_i, s1_gnt_o, s1_we_i, s1_rvalid_o, s1_err_o;
    logic [3:0]  s1_be_i;
    logic [31:0] s1_addr_i, s1_wdata_i, s1_rdata_o;
    logic        m_req_o, m_gnt_i, m_we_o, m_rvalid_i, m_err_i, m_pending_o, proto_err_o;
    logic [3:0]  m_be_o;
    logic [31:0] m_addr_o, m_wdata_o, m_rdata_i;

    obi_dbus_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
        .hclk_i(clk), .hresetn_i(rst_n),
        .s0_req_i(s0_req_i), .s0_gnt_o(s0_gnt_o), .s0_we_i(s0_we_i), .s0_be_i(s0_be_i),
        .s0_addr_i(s0_addr_i), .s0_wdata_i(s0_wdata_i), .s0_rvalid_o(s0_rvalid_o),
        .s0_rdata_o(s0_rdata_o), .s0_err_o(s0_err_o),
        .s1_req_i(s1_req_i), .s1_gnt_o(s1_gnt_o), .s1_we_i(s1_we_i), .s1_be_i(s1_be_i),
        .s1_addr_i(s1_addr_i), .s1_wdata_i(s1_wdata_i), .s1_rvalid_o(s1_rvalid_o),
        .s1_rdata_o(s1_rdata_o), .s1_err_o(s1_err_o),
        .m_req_o(m_req_o), .m_gnt_i(m_gnt_i), .m_we_o(m_we_o), .m_be_o(m_be_o),
        .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o), .m_rvalid_i(m_rvalid_i),
        .m_rdata_i(m_rdata_i), .m_err_i(m_err_i), .m_pending_o(m_pending_o),
        .proto_err_o(proto_err_o)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: outstanding requesters in order, a locked requester (or -1), last grant
    int q[$];
    int lock = -1;
    int lg   = 1;
    bit perr = 1'b0;

    logic        e_req, e_gnt0, e_gnt1, e_we, e_rv0, e_rv1, e_err0, e_err1, e_pend;
    int          e_sel;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata, e_rd0, e_rd1;

    function automatic void model_eval();
        bit full;
        bit routed;
        int win;
        int head;
        full = (q.size() >= MAX);
        if (s0_req_i && s1_req_i) win = FIXED ? 0 : 1 - lg;
        else                      win = s0_req_i ? 0 : 1;
        e_req = 1'b0;
        e_sel = 0;
        if (lock >= 0) begin
            e_req = 1'b1;
            e_sel = lock;
        end else if ((s0_req_i || s1_req_i) && (!full || m_rvalid_i)) begin
            e_req = 1'b1;
            e_sel = win;
        end
        e_gnt0  = m_gnt_i && e_req && (e_sel == 0);
        e_gnt1  = m_gnt_i && e_req && (e_sel == 1);
        e_we    = !e_req ? 1'b0  : (e_sel == 1 ? s1_we_i    : s0_we_i);
        e_be    = !e_req ? 4'h0  : (e_sel == 1 ? s1_be_i    : s0_be_i);
        e_addr  = !e_req ? 32'h0 : (e_sel == 1 ? s1_addr_i  : s0_addr_i);
        e_wdata = !e_req ? 32'h0 : (e_sel == 1 ? s1_wdata_i : s0_wdata_i);
        routed  = m_rvalid_i && (q.size() > 0);
        head    = routed ? q[0] : -1;
        e_rv0   = (head == 0);
        e_rv1   = (head == 1);
        e_rd0   = e_rv0 ? m_rdata_i : 32'h0;
        e_rd1   = e_rv1 ? m_rdata_i : 32'h0;
        e_err0  = e_rv0 && m_err_i;
        e_err1  = e_rv1 && m_err_i;
        e_pend  = full && !m_rvalid_i;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            lock = -1;
            lg   = 1;
            perr = 1'b0;
        end else begin
            model_eval();
            if (m_rvalid_i) begin
                if (q.size() > 0) void'(q.pop_front());
                else perr = 1'b1;
            end
            if (e_req && m_gnt_i) begin
                q.push_back(e_sel);
                lg   = e_sel;
                lock = -1;
            end else if (e_req) begin
                lock = e_sel;
            end
        end
    end

    always @(negedge clk) begin
        model_eval();
        chk("m_req",     m_req_o,     e_req);
        chk("m_we",      m_we_o,      e_we);
        chk("m_be",      m_be_o,      e_be);
        chk("m_addr",    m_addr_o,    e_addr);
        chk("m_wdata",   m_wdata_o,   e_wdata);
        chk("s0_gnt",    s0_gnt_o,    e_gnt0);
        chk("s1_gnt",    s1_gnt_o,    e_gnt1);
        chk("s0_rvalid", s0_rvalid_o, e_rv0);
        chk("s1_rvalid", s1_rvalid_o, e_rv1);
        chk("s0_rdata",  s0_rdata_o,  e_rd0);
        chk("s1_rdata",  s1_rdata_o,  e_rd1);
        chk("s0_err",    s0_err_o,    e_err0);
        chk("s1_err",    s1_err_o,    e_err1);
        chk("m_pending", m_pending_o, e_pend);
        chk("proto_err", proto_err_o, perr);
    end

    task automatic clear_inputs();
        s0_req_i = 0; s0_we_i = 0; s0_be_i = 4'hF; s0_addr_i = 0; s0_wdata_i = 0;
        s1_req_i = 0; s1_we_i = 0; s1_be_i = 4'hF; s1_addr_i = 0; s1_wdata_i = 0;
        m_gnt_i = 0; m_rvalid_i = 0; m_rdata_i = 0; m_err_i = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] t2_g0;
        logic [2:0] t2_g1;
        clear_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_m_req",   m_req_o,     0);
        chk("rst_pending", m_pending_o, 0);
        chk("rst_proto",   proto_err_o, 0);
        chk("rst_s0_gnt",  s0_gnt_o,    0);
        cyc(); rst_n = 1;

        // 1: single read, response next cycle
        cyc(); s0_req_i = 1; s0_addr_i = 32'h1000; m_gnt_i = 1;
        @(negedge clk);
        chk("t1_s0_gnt", s0_gnt_o, 1);
        chk("t1_s1_gnt", s1_gnt_o, 0);
        chk("t1_addr",   m_addr_o, 32'h1000);
        cyc(); clear_inputs(); m_rvalid_i = 1; m_rdata_i = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1_s0_rvalid", s0_rvalid_o, 1);
        chk("t1_s0_rdata",  s0_rdata_o,  32'hDEADBEEF);
        chk("t1_s1_rvalid", s1_rvalid_o, 0);
        cyc(); clear_inputs();
        rst_n = 0; cyc(); rst_n = 1;

        // 2: both request three times with immediate grant
        t2_g0 = FIXED ? 3'b111 : 3'b101;
        t2_g1 = FIXED ? 3'b000 : 3'b010;
        cyc(); s0_req_i = 1; s1_req_i = 1; s0_addr_i = 32'hA0; s1_addr_i = 32'hB0; m_gnt_i = 1;
        for (int i = 0; i < 3; i++) begin
            m_rvalid_i = (i > 0);
            m_rdata_i  = 32'h100 + 32'(i);
            @(negedge clk);
            chk("t2_s0_gnt", s0_gnt_o, 32'(t2_g0[i]));
            chk("t2_s1_gnt", s1_gnt_o, 32'(t2_g1[i]));
            cyc();
        end
        clear_inputs(); m_rvalid_i = 1;
        cyc(); clear_inputs();

        // 3: s1 held while grant is low, s0 joins and waits
        s1_req_i = 1; s1_addr_i = 32'h3000; s0_addr_i = 32'h4000;
        @(negedge clk); chk("t3_addr_c0", m_addr_o, 32'h3000);
        cyc(); s0_req_i = 1;
        @(negedge clk); chk("t3_addr_c1", m_addr_o, 32'h3000);
        cyc();
        @(negedge clk); chk("t3_addr_c2", m_addr_o, 32'h3000);
        cyc(); m_gnt_i = 1;
        @(negedge clk);
        chk("t3_s1_gnt", s1_gnt_o, 1);
        chk("t3_s0_gnt_wait", s0_gnt_o, 0);
        cyc(); s1_req_i = 0;
        @(negedge clk);
        chk("t3_s0_gnt", s0_gnt_o, 1);
        chk("t3_addr_s0", m_addr_o, 32'h4000);
        cyc(); clear_inputs(); m_rvalid_i = 1;
        cyc(); cyc(); clear_inputs();

        // 4: fill to MAX, then retire-and-accept in one cycle
        s0_req_i = 1; s0_addr_i = 32'h5000; m_gnt_i = 1;
        @(negedge clk); chk("t4_acc0", s0_gnt_o, 1);
        cyc();
        @(negedge clk); chk("t4_acc1", s0_gnt_o, 1);
        cyc();
        @(negedge clk);
        chk("t4_pending", m_pending_o, 1);
        chk("t4_req_blk", m_req_o,     0);
        cyc(); m_rvalid_i = 1;
        @(negedge clk);
        chk("t4_req_swap", m_req_o,     1);
        chk("t4_gnt_swap", s0_gnt_o,    1);
        chk("t4_pend_rv",  m_pending_o, 0);
        cyc(); m_rvalid_i = 0;
        @(negedge clk);
        chk("t4_still_full", m_pending_o, 1);
        cyc(); clear_inputs(); m_rvalid_i = 1;
        cyc(); cyc(); clear_inputs();

        // 5: s1 write answered with error
        s1_req_i = 1; s1_we_i = 1; s1_addr_i = 32'h2000; s1_wdata_i = 32'h55AA; m_gnt_i = 1;
        @(negedge clk);
        chk("t5_s1_gnt", s1_gnt_o,  1);
        chk("t5_we",     m_we_o,    1);
        chk("t5_wdata",  m_wdata_o, 32'h55AA);
        cyc(); clear_inputs(); m_rvalid_i = 1; m_err_i = 1;
        @(negedge clk);
        chk("t5_s1_rvalid", s1_rvalid_o, 1);
        chk("t5_s1_err",    s1_err_o,    1);
        chk("t5_s0_err",    s0_err_o,    0);
        cyc(); clear_inputs();

        // 6: stray response, held request, async reset, late response
        m_rvalid_i = 1;
        @(negedge clk);
        chk("t6_stray_rv0", s0_rvalid_o, 0);
        chk("t6_stray_rv1", s1_rvalid_o, 0);
        cyc(); clear_inputs();
        @(negedge clk); chk("t6_proto_set", proto_err_o, 1);
        s0_req_i = 1; s0_addr_i = 32'h6000;
        cyc(); s0_req_i = 0;
        @(negedge clk);
        chk("t6_hold_req",  m_req_o,  1);
        chk("t6_hold_addr", m_addr_o, 32'h6000);
        cyc(); clear_inputs(); rst_n = 0;
        #2;
        chk("t6_rst_req",   m_req_o,     0);
        chk("t6_rst_proto", proto_err_o, 0);
        chk("t6_rst_pend",  m_pending_o, 0);
        chk("t6_rst_addr",  m_addr_o,    0);
        cyc(); rst_n = 1;
        cyc(); m_rvalid_i = 1;
        @(negedge clk); chk("t6_late_rv0", s0_rvalid_o, 0);
        cyc(); clear_inputs();
        @(negedge clk); chk("t6_late_proto", proto_err_o, 1);

        repeat (2) cyc();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
